// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Master issues req/we/addr/wstrb/wdata; slave answers with ack and rdata.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wstrb, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: decodes loads/stores, runs one req/ack transaction
// per access while stalling upstream, and produces the MEM/WB write-back value.
module mem_access_stage (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_inst,
  input  logic [31:0]          ex_alu_result,
  input  logic [31:0]          ex_rs2_data,
  input  logic                 ex_rf_we,
  mem_access_stage_if.master   dmem,
  output logic                 mem_stall,
  output logic [31:0]          mem_pc,
  output logic [31:0]          mem_inst,
  output logic                 mem_rf_we,
  output logic [31:0]          mem_rf_wd,
  output logic                 misalign_exc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] rs2);
    case (sz)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {off, 3'b000});
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return rdata;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [1:0] off;
  logic       is_load, is_store, legal, aligned, illegal_mem, misaligned, mem_op;

  assign opcode   = ex_inst[6:0];
  assign funct3   = ex_inst[14:12];
  assign rd       = ex_inst[11:7];
  assign off      = ex_alu_result[1:0];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign legal    = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                    (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
  assign aligned  = (funct3[1:0] == 2'b00) ||
                    (funct3[1:0] == 2'b01 && !off[0]) ||
                    (off == 2'b00);

  // Unknown funct3 on a load/store opcode is squashed silently: no access, no write, no trap.
  assign illegal_mem = (is_load || is_store) && !legal;
  assign misaligned  = ex_valid && legal && !aligned;
  assign mem_op      = ex_valid && legal && aligned;

  assign mem_stall    = (state == BUSY) || (state == IDLE && mem_op);
  assign misalign_exc = misaligned && (state == IDLE);
  assign mem_pc       = ex_pc;
  assign mem_inst     = ex_inst;
  assign mem_rf_wd    = (state == DONE && is_load) ? load_q : ex_alu_result;
  assign mem_rf_we    = ex_valid && ex_rf_we && !is_store && !misaligned && !illegal_mem &&
                        (rd != 5'd0) && !(mem_op && state != DONE);

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wstrb = strb_q;
  assign dmem.wdata = wdata_q;

  // IDLE -> BUSY launches the request; ack in BUSY captures load data; DONE lets EX/MEM advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      load_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (mem_op) begin
          req_q   <= 1'b1;
          we_q    <= is_store;
          addr_q  <= {ex_alu_result[31:2], 2'b00};
          strb_q  <= is_store ? store_strb(funct3[1:0], off) : 4'b0000;
          wdata_q <= store_data(funct3[1:0], ex_rs2_data);
          state   <= BUSY;
        end
        BUSY: if (dmem.ack) begin
          req_q  <= 1'b0;
          load_q <= load_ext(funct3, off, dmem.rdata);
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a behavioural
// model of RV32I load/store lane placement and extension.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0, ex_inst = '0, ex_alu_result = '0, ex_rs2_data = '0;
  logic        ex_rf_we = 1'b0;
  logic        mem_stall, mem_rf_we, misalign_exc;
  logic [31:0] mem_pc, mem_inst, mem_rf_wd;
  int          checks = 0;
  int          errors = 0;

  mem_access_stage_if bus();

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rf_we(ex_rf_we),
    .dmem(bus), .mem_stall(mem_stall), .mem_pc(mem_pc), .mem_inst(mem_inst),
    .mem_rf_we(mem_rf_we), .mem_rf_wd(mem_rf_wd), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Drives one instruction into MEM and follows it until it leaves, checking every cycle.
  task automatic exec_inst(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input logic rfwe, input int k, input string tag);
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          ld, st, legal, memop, misal, exp_we;
    int          nb, o, stalls;
    logic [31:0] v, exp_wd, exp_wdata, pc;
    logic [3:0]  exp_strb;
    logic [71:0] got_bus, exp_bus;
    op = inst[6:0]; f3 = inst[14:12];
    ld = (op == 7'h03); st = (op == 7'h23);
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : st ? (f3 <= 3'd2) : 1'b0;
    nb = 1 << f3[1:0];
    o = int'(addr[1:0]);
    memop = legal && (o % nb == 0);
    misal = legal && (o % nb != 0);
    exp_we = rfwe && !st && !((ld || st) && !legal) && !misal && (inst[11:7] != 5'd0);
    v = rdata >> (8 * o);
    if (nb == 1) begin v = v & 32'hFF; if (f3 == 3'd0 && v >= 128) v = v - 256; end
    else if (nb == 2) begin v = v & 32'hFFFF; if (f3 == 3'd1 && v >= 32768) v = v - 65536; end
    else v = rdata;
    exp_wd = (ld && memop) ? v : addr;
    exp_strb = st ? 4'(((1 << nb) - 1) << o) : 4'd0;
    exp_wdata = (nb == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
    pc = $urandom;

    @(posedge clk); #1;
    ex_valid = 1'b1; ex_inst = inst; ex_alu_result = addr; ex_rs2_data = rs2;
    ex_rf_we = rfwe; ex_pc = pc; bus.ack = 1'(($urandom % 2)); bus.rdata = $urandom;
    @(negedge clk);
    checks++; if ({mem_pc, mem_inst} !== {pc, inst}) begin errors++;
      $display("FAIL %s pc_inst got %h/%h exp %h/%h", tag, mem_pc, mem_inst, pc, inst); end
    checks++; if (misalign_exc !== misal) begin errors++;
      $display("FAIL %s misalign_exc got %0b exp %0b", tag, misalign_exc, misal); end
    if (!memop) begin
      checks++; if ({mem_stall, bus.req} !== 2'b00) begin errors++;
        $display("FAIL %s pass_stall_req got %0b%0b exp 00", tag, mem_stall, bus.req); end
      checks++; if ({mem_rf_we, mem_rf_wd} !== {exp_we, addr}) begin errors++;
        $display("FAIL %s pass_wb got %0b/%h exp %0b/%h", tag, mem_rf_we, mem_rf_wd, exp_we, addr); end
    end else begin
      stalls = int'(mem_stall);
      checks++; if ({mem_stall, bus.req, mem_rf_we} !== 3'b100) begin errors++;
        $display("FAIL %s idle_ctrl got stall=%0b req=%0b we=%0b exp 1/0/0", tag, mem_stall, bus.req, mem_rf_we); end
      for (int c = 1; c <= k; c++) begin
        @(posedge clk); #1;
        bus.ack = (c == k); bus.rdata = (c == k) ? rdata : $urandom;
        @(negedge clk);
        stalls += int'(mem_stall);
        got_bus = {1'b0, bus.req, bus.we, bus.addr, bus.wstrb, mem_stall, mem_rf_we, 32'd0};
        exp_bus = {1'b0, 1'b1, st, addr[31:2], 2'b00, exp_strb, 1'b1, 1'b0, 32'd0};
        checks++; if (got_bus !== exp_bus) begin errors++;
          $display("FAIL %s busy%0d req/we/addr/strb/stall/rfwe got %h exp %h", tag, c, got_bus[71:32], exp_bus[71:32]); end
        if (st) begin
          checks++; if (bus.wdata !== exp_wdata) begin errors++;
            $display("FAIL %s busy%0d wdata got %h exp %h", tag, c, bus.wdata, exp_wdata); end
        end
      end
      @(posedge clk); #1;
      bus.ack = 1'(($urandom % 2)); bus.rdata = $urandom;
      @(negedge clk);
      stalls += int'(mem_stall);
      checks++; if ({bus.req, mem_stall} !== 2'b00) begin errors++;
        $display("FAIL %s done_req_stall got %0b%0b exp 00", tag, bus.req, mem_stall); end
      checks++; if ({mem_rf_we, mem_rf_wd} !== {exp_we, exp_wd}) begin errors++;
        $display("FAIL %s done_wb got %0b/%h exp %0b/%h", tag, mem_rf_we, mem_rf_wd, exp_we, exp_wd); end
      checks++; if (stalls != k + 1) begin errors++;
        $display("FAIL %s stall_cycles got %0d exp %0d", tag, stalls, k + 1); end
    end
  endtask

  task automatic drop_valid(input string tag);
    @(posedge clk); #1;
    ex_valid = 1'b0; bus.ack = 1'b0;
    @(negedge clk);
    checks++; if ({mem_stall, mem_rf_we, misalign_exc, bus.req} !== 4'b0000) begin errors++;
      $display("FAIL %s bubble got stall/we/exc/req=%0b%0b%0b%0b exp 0000", tag, mem_stall, mem_rf_we, misalign_exc, bus.req); end
  endtask

  task automatic test_reset();
    bus.ack = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.req, bus.we, bus.addr, bus.wstrb, bus.wdata} !== 70'd0) begin errors++;
      $display("FAIL reset_bus got req=%0b we=%0b addr=%h strb=%h wdata=%h exp all 0", bus.req, bus.we, bus.addr, bus.wstrb, bus.wdata); end
    checks++; if ({mem_stall, mem_rf_we, misalign_exc} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl got %0b%0b%0b exp 000", mem_stall, mem_rf_we, misalign_exc); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_alu();
    exec_inst(32'h00500093, 32'd5, 32'd0, 32'd0, 1'b1, 1, "alu_addi");
    drop_valid("alu");
  endtask

  task automatic test_loads();
    exec_inst(32'h00000283, 32'h1003, 32'd0, 32'h80FFFF00, 1'b1, 1, "lb");
    drop_valid("lb");
    exec_inst(32'h00005303, 32'h2002, 32'd0, 32'hBEEF1234, 1'b1, 1, "lhu_k1");
    drop_valid("lhu_k1");
    exec_inst(32'h00005303, 32'h2002, 32'd0, 32'hBEEF1234, 1'b1, 3, "lhu_k3");
    drop_valid("lhu_k3");
  endtask

  task automatic test_store();
    exec_inst(32'h002080A3, 32'h3001, 32'h123456AB, 32'd0, 1'b1, 2, "sb");
    drop_valid("sb");
  endtask

  task automatic test_misalign();
    exec_inst(32'h00002383, 32'h4002, 32'd0, 32'd0, 1'b1, 1, "lw_misal");
    drop_valid("lw_misal");
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_inst = 32'h0000A383; ex_alu_result = 32'h6000; ex_rf_we = 1'b1; bus.ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.req !== 1'b1) begin errors++;
      $display("FAIL rst_busy pre_req got %0b exp 1", bus.req); end
    #2 rst_n = 1'b0; ex_valid = 1'b0;
    #1;
    checks++; if ({bus.req, bus.addr, mem_stall} !== 34'd0) begin errors++;
      $display("FAIL rst_busy async got req=%0b addr=%h stall=%0b exp 0", bus.req, bus.addr, mem_stall); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.req, mem_stall} !== 2'b00) begin errors++;
      $display("FAIL rst_busy after got req=%0b stall=%0b exp 00", bus.req, mem_stall); end
    exec_inst(32'h0020A023, 32'h5000, 32'hCAFEF00D, 32'd0, 1'b0, 1, "sw_after_rst");
    drop_valid("sw_after_rst");
  endtask

  task automatic test_back_to_back();
    exec_inst(32'h0000A403, 32'h7004, 32'd0, 32'h89ABCDEF, 1'b1, 1, "b2b_lw");
    exec_inst(32'h0020A023, 32'h7008, 32'h11223344, 32'd0, 1'b1, 2, "b2b_sw");
    exec_inst(32'h00004483, 32'h700A, 32'd0, 32'h00F70000, 1'b1, 1, "b2b_lbu");
    drop_valid("b2b");
  endtask

  task automatic test_random();
    logic [31:0] inst;
    logic [6:0]  ops [3];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h13;
    for (int i = 0; i < 80; i++) begin
      inst = $urandom;
      inst[6:0] = ops[$urandom % 3];
      exec_inst(inst, $urandom, $urandom, $urandom, 1'(($urandom % 2)), 1 + int'($urandom % 4), "rand");
      if ($urandom % 4 == 0) drop_valid("rand");
    end
    drop_valid("rand_end");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_store();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage RV32I pipeline, sitting between the EX/MEM register and the MEM/WB register. It decodes loads and stores from the instruction in MEM, runs a req/ack transaction on the data-memory port, and stalls the upstream pipeline while the access is outstanding. It aligns store data, sign- or zero-extends load data, and presents the final write-back value and write enable to MEM/WB.

## Interface
- Parameters: none.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_pc  in  32  PC of the instruction in MEM.
- ex_inst  in  32  instruction in MEM. opcode [6:0], rd [11:7], funct3 [14:12].
- ex_alu_result  in  32  effective address for loads/stores; write-back value otherwise.
- ex_rs2_data  in  32  store source data.
- ex_rf_we  in  1  register write enable decoded in ID.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB keeps clocking.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word address, with bits [1:0] forced to 00.
- dmem_wstrb  out  4  byte-lane write strobes.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  load data word.
- mem_pc  out  32  equals ex_pc.
- mem_inst  out  32  equals ex_inst.
- mem_rf_we  out  1  write enable to MEM/WB.
- mem_rf_wd  out  32  write-back data to MEM/WB.
- misalign_exc  out  1  misaligned access flag, one cycle.

## Operation
- Decode:
  - load = opcode 0000011; store = opcode 0100011; mem_op = ex_valid & (load | store) & legal & aligned.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Other funct3 values: no access, mem_rf_we=0, no exception.
- Alignment: a halfword access requires addr[0]=0; a word access requires addr[1:0]=00.
- Misaligned access:
  - No request is issued and mem_stall=0.
  - misalign_exc=1 combinationally while the instruction is in IDLE.
  - mem_rf_we=0.
- Store lanes (o = addr[1:0]):
  - SB: wstrb = 0001<<o; wdata = rs2[7:0] replicated into all 4 bytes.
  - SH: wstrb = 0011 when o=00, 1100 when o=10; wdata = rs2[15:0] replicated into both halves.
  - SW: wstrb = 1111; wdata = rs2.
  - Loads: wstrb = 0000.
- Load extraction: select the byte or half lane by o from the rdata captured at ack, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if mem_op, set mem_stall=1; at the next edge, register dmem_* and go to BUSY. Otherwise mem_stall=0 and the stage is a passthrough.
  - BUSY: dmem_req=1, with addr/we/wstrb/wdata held stable. mem_stall=1. When dmem_ack=1 at a posedge, capture the extended load data in load_q and go to DONE.
  - DONE: dmem_req=0, mem_stall=0. At the next edge EX/MEM advances and the state returns to IDLE.
- Write-back value:
  - mem_rf_wd = load_q in DONE for a load; otherwise ex_alu_result.
  - mem_rf_we = ex_valid & ex_rf_we & ~store & ~misaligned & (rd≠0), and is 0 in IDLE/BUSY for a mem_op.
- dmem_ack outside BUSY is ignored.

## Timing
- Reset (asynchronous):
  - State returns to IDLE and load_q=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wstrb=0, dmem_wdata=0, effective immediately, including aborting a BUSY access.
- Combinational outputs under reset follow the IDLE rules. With ex_valid=0: mem_stall=0, mem_rf_we=0, misalign_exc=0.
- Non-memory instruction: zero added latency; mem_rf_wd and mem_rf_we are combinational from the ex_* inputs.
- Memory instruction timeline, with ack arriving in the k-th BUSY cycle (k≥1):
  - The instruction occupies MEM for k+2 cycles: IDLE, k×BUSY, DONE.
  - mem_stall is high for k+1 cycles.
  - Minimum added stall is 2 cycles.
- Upstream contract: ex_* stay stable while mem_stall=1, so no flush can occur during IDLE→DONE.
- Back-to-back memory operations: DONE → IDLE at the edge where the next instruction enters MEM, so no bubble is inserted between accesses.
- dmem_req is high only in BUSY and drops in the cycle after ack.

## Test plan
- ALU op, inst=0x00500093 (addi x1,x0,5), alu_result=5, rf_we=1 → same cycle: mem_rf_we=1, mem_rf_wd=5, mem_stall=0, dmem_req never asserted.
- LB, addr=0x1003, ack in first BUSY cycle with rdata=0x80FF_FF00:
  - Request: dmem_addr=0x1000, wstrb=0000.
  - mem_stall is high for exactly 2 cycles.
  - In DONE: mem_rf_wd=0xFFFF_FF80, mem_rf_we=1.
- LHU addr=0x2002 with rdata=0xBEEF_1234 → mem_rf_wd=0x0000_BEEF. Repeat with ack delayed 3 BUSY cycles → mem_stall high for 4 cycles, and addr/req stay stable throughout.
- SB, addr=0x3001, rs2=0x1234_56AB:
  - dmem_we=1, wstrb=0010, wdata=0xABAB_ABAB.
  - mem_rf_we=0 in every state.
- LW addr=0x4002 → misalign_exc=1 for 1 cycle, dmem_req stays 0, mem_stall=0, mem_rf_we=0.
- rst_n pulsed low during BUSY → dmem_req=0 at once and state returns to IDLE. After release, an SW to 0x5000 completes normally with wstrb=1111.
